// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: sync, debounce and edge-detect car sensors and parade buttons; SENSOR_HOLD_EN adds Ta/Tb hold-off.
module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sa_raw,
  input  logic sb_raw,
  input  logic p_btn,
  input  logic r_btn,
  output logic Ta,
  output logic Tb,
  output logic P,
  output logic R,
  output logic err
);
  logic [3:0] s1, s2, held, flip, rise;
  logic [7:0] cnt [4];
  logic p_q, r_q, err_q;
  always_comb begin
    flip = '0;
    for (int c = 0; c < 4; c++)
      flip[c] = (s2[c] != held[c]) && (cnt[c] == 8'(DEB_CYCLES - 1));
    rise = flip & ~held;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      held <= '0;
      for (int c = 0; c < 4; c++) cnt[c] <= '0;
      p_q <= 1'b0;
      r_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1 <= {r_btn, p_btn, sb_raw, sa_raw};
      s2 <= s1;
      held <= held ^ flip;
      for (int c = 0; c < 4; c++) cnt[c] <= (s2[c] == held[c] || flip[c]) ? 8'd0 : cnt[c] + 8'd1;
      p_q <= rise[2] & ~rise[3];
      r_q <= rise[3];
      err_q <= rise[2] & rise[3];
    end
  end
  assign P = p_q;
  assign R = r_q;
  assign err = err_q;
`ifdef SENSOR_HOLD_EN
  logic [7:0] hcnt [2];
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      hcnt[c] <= rst ? 8'd0 :
                 (flip[c] & held[c]) ? 8'(HOLD_CYCLES) :
                 (flip[c] | hcnt[c] == 8'd0) ? 8'd0 : hcnt[c] - 8'd1;
  end
  assign Ta = held[0] | (hcnt[0] != 8'd0);
  assign Tb = held[1] | (hcnt[1] != 8'd0);
`else
  assign Ta = held[0];
  assign Tb = held[1];
`endif
endmodule
